writeback_arbiter: RTL and testbench
====================================

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports alu_valid/alu_rd/alu_data  input  1/5/32  single-cycle ALU result; no backpressure.
REQ-004 SHALL have ports ld_valid/ld_rd/ld_data  input  1/5/32, and ld_ready  output  1  load-unit result handshake.
REQ-005 SHALL have ports md_valid/md_rd/md_data  input  1/5/32, and md_ready  output  1  multi-cycle mul/div result handshake.
REQ-006 SHALL have ports issue_valid/issue_rd  input  1/5  an instruction targeting rd was issued; marks rd pending.
REQ-007 SHALL have ports rs1/rs2  input  5/5 and rs1_busy/rs2_busy  output  1/1  pending-write query for operand fetch.
REQ-008 SHALL have ports write_enable/rd  output  1/5 and write_data  output  32 signed  register-file write port drive.

Function
REQ-009 SHALL accept at most one result per cycle; priority: ALU over load/md; load vs md arbitrated round-robin.
REQ-010 SHALL assert ld_ready/md_ready combinationally only when alu_valid=0 and that source holds the round-robin grant or the other source is not valid.
REQ-011 SHALL transfer on valid&&ready; source must hold rd/data stable while valid&&!ready.
REQ-012 SHALL update round-robin pointer only when both load and md were valid and one was granted; pointer favours the source not granted last.
REQ-013 SHALL register the accepted result: write_enable/rd/write_data valid the cycle after acceptance (latency 1), write_enable high exactly one cycle per accepted result.
REQ-014 SHALL force write_enable=0 for accepted results with rd=0 (handshake still completes; data discarded).
REQ-015 SHALL keep a 32-bit pending bitmap; bit[0] permanently 0.
REQ-016 SHALL set pending[issue_rd] on issue_valid when issue_rd!=0.
REQ-017 SHALL clear pending[rd] on the cycle write_enable is high.
REQ-018 SHALL, when set and clear target the same rd in one cycle, leave the bit set (newer issue wins).
REQ-019 SHALL drive rs1_busy = pending[rs1] || (write_enable=0 pending bypass none) i.e. pending[rs1] only; same for rs2; combinational, reflects current-cycle bitmap.
REQ-020 SHALL not bypass: a register being written this cycle still reads busy until the following cycle.
REQ-021 SHALL ignore ld_valid/md_valid (no transfer) while rst_n low.

Reset
REQ-022 SHALL, on rst_n low, immediately clear pending bitmap, write_enable, rd, write_data, and set round-robin pointer to load.
REQ-023 SHALL drive ld_ready=md_ready=0 while rst_n low.
REQ-024 SHALL, on reset mid-operation, drop any registered-but-unwritten result (write_enable forced 0 that cycle).
REQ-025 SHALL resume normal acceptance on the first rising edge after rst_n deasserts.

Structure
REQ-026 SHALL place REG_ADDR_W=5, XLEN=32, NUM_REGS=32 and the source-select enum (SRC_ALU, SRC_LD, SRC_MD) in the shared cpu package.
REQ-027 SHALL implement the pending bitmap as one sub-module named reg_scoreboard (set/clear/query ports); arbiter and output register remain in writeback_arbiter.

Verification
REQ-028 ALU alone: alu_valid=1, rd=5, data=0x1234 -> next cycle write_enable=1, rd=5, write_data=0x1234, one cycle only.
REQ-029 Contention: alu(rd3), ld(rd4), md(rd6) valid same cycle, held -> writes in order rd3, rd4, rd6 on three consecutive cycles; ld_ready=md_ready=0 in first cycle.
REQ-030 Round-robin: ld and md continuously valid, no ALU -> grants alternate ld, md, ld, md starting with ld after reset.
REQ-031 x0 write: ld_valid rd=0 data=0xFFFFFFFF -> ld_ready=1, write_enable stays 0, pending unchanged.
REQ-032 Scoreboard: issue rd=7; rs1=7 -> rs1_busy=1 until the cycle after write_enable with rd=7; simultaneous issue rd=7 and write rd=7 -> rs1_busy stays 1.
REQ-033 Reset mid-flight: accept md rd=9, assert rst_n=0 before next edge -> write_enable never asserts, all pending bits read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry, data width and the
// writeback source-select encoding used by the arbiter and its scoreboard.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;
  typedef logic signed [XLEN-1:0] xlen_data_t;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_LD  = 2'd1,
    SRC_MD  = 2'd2
  } src_sel_e;

  typedef struct packed {
    logic       valid;
    src_sel_e   src;
    reg_addr_t  rd;
    xlen_data_t data;
  } wb_grant_t;

  // x0 is hardwired to zero, so results aimed at it are never written.
  function automatic logic writes_reg(input reg_addr_t addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bus: three result sources, issue/operand-query side channel and
// the register-file write port.
interface writeback_arbiter_if;
  import cpu_pkg::*;

  logic       alu_valid;
  reg_addr_t  alu_rd;
  xlen_data_t alu_data;

  logic       ld_valid;
  reg_addr_t  ld_rd;
  xlen_data_t ld_data;
  logic       ld_ready;

  logic       md_valid;
  reg_addr_t  md_rd;
  xlen_data_t md_data;
  logic       md_ready;

  logic       issue_valid;
  reg_addr_t  issue_rd;

  reg_addr_t  rs1;
  reg_addr_t  rs2;
  logic       rs1_busy;
  logic       rs2_busy;

  logic       write_enable;
  reg_addr_t  rd;
  xlen_data_t write_data;

  // Pipeline / test side: produces results and queries, observes the write port.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output md_valid, md_rd, md_data,
    input  md_ready,
    output issue_valid, issue_rd,
    output rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  write_enable, rd, write_data
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  md_valid, md_rd, md_data,
    output md_ready,
    input  issue_valid, issue_rd,
    input  rs1, rs2,
    output rs1_busy, rs2_busy,
    output write_enable, rd, write_data
  );

endinterface

// File: rtl/writeback_arbiter_scoreboard.sv
// Pending-write bitmap: one bit per architectural register, set on issue,
// cleared on writeback; a same-cycle set beats the clear.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_valid,
  input  reg_addr_t set_addr,
  input  logic      clr_valid,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  output logic      rs1_busy,
  output logic      rs2_busy
);

  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_hit;
        logic clr_hit;
        assign set_hit = set_valid && (set_addr == REG_ADDR_W'(gi));
        assign clr_hit = clr_valid && (clr_addr == REG_ADDR_W'(gi));
        // Newer issue wins over a retiring write to the same register.
        assign pending_next[gi] = set_hit || (pending_reg[gi] && !clr_hit);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  // No bypass: a register retiring this cycle still reads busy.
  assign rs1_busy = pending_reg[rs1_addr];
  assign rs2_busy = pending_reg[rs2_addr];

endmodule

// File: rtl/writeback_arbiter.sv
// Single-port writeback arbiter: ALU has absolute priority, load and mul/div
// share the remaining slot round-robin; accepted result is registered once.
module writeback_arbiter
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  writeback_arbiter_if.slave  bus
);

  src_sel_e   rr_ptr_reg;
  src_sel_e   rr_ptr_next;
  logic       ld_ready;
  logic       md_ready;
  wb_grant_t  grant;

  logic       we_reg;
  reg_addr_t  rd_reg;
  xlen_data_t data_reg;

  // Ready is withheld during reset so nothing transfers while rst_n is low.
  always_comb begin
    ld_ready = 1'b0;
    md_ready = 1'b0;
    if (rst_n && !bus.alu_valid) begin
      ld_ready = (rr_ptr_reg == SRC_LD) || !bus.md_valid;
      md_ready = (rr_ptr_reg == SRC_MD) || !bus.ld_valid;
    end
  end

  assign bus.ld_ready = ld_ready;
  assign bus.md_ready = md_ready;

  always_comb begin
    grant = '{valid: 1'b0, src: SRC_ALU, rd: '0, data: '0};
    if (bus.alu_valid) begin
      grant = '{valid: 1'b1, src: SRC_ALU, rd: bus.alu_rd, data: bus.alu_data};
    end else if (bus.ld_valid && ld_ready) begin
      grant = '{valid: 1'b1, src: SRC_LD, rd: bus.ld_rd, data: bus.ld_data};
    end else if (bus.md_valid && md_ready) begin
      grant = '{valid: 1'b1, src: SRC_MD, rd: bus.md_rd, data: bus.md_data};
    end
  end

  // Pointer only moves when load and mul/div actually contended.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (bus.ld_valid && bus.md_valid && grant.valid && grant.src != SRC_ALU) begin
      rr_ptr_next = (grant.src == SRC_LD) ? SRC_MD : SRC_LD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= SRC_LD;
      we_reg     <= 1'b0;
      rd_reg     <= '0;
      data_reg   <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      we_reg     <= grant.valid && writes_reg(grant.rd);
      if (grant.valid) begin
        rd_reg   <= grant.rd;
        data_reg <= grant.data;
      end
    end
  end

  assign bus.write_enable = we_reg;
  assign bus.rd           = rd_reg;
  assign bus.write_data   = data_reg;

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_valid (bus.issue_valid),
    .set_addr  (bus.issue_rd),
    .clr_valid (we_reg),
    .clr_addr  (rd_reg),
    .rs1_addr  (bus.rs1),
    .rs2_addr  (bus.rs2),
    .rs1_busy  (bus.rs1_busy),
    .rs2_busy  (bus.rs2_busy)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: reset, ALU path, round-robin,
// contention, x0 discard, scoreboard set/clear and mid-flight reset.
module tb_writeback_arbiter;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  writeback_arbiter_if bus();

  writeback_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.write_enable === 1'b1)
      $display("wb: rd=%0d data=%h", bus.rd, bus.write_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid = 1'b0;  bus.ld_rd = '0;  bus.ld_data = '0;
    bus.md_valid = 1'b0;  bus.md_rd = '0;  bus.md_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.rs1 = '0; bus.rs2 = '0;
    rst_n = 1'b0;

    // Reset: sources valid but nothing may be accepted
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd1; bus.ld_data = 32'h1;
    bus.md_valid = 1'b1; bus.md_rd = 5'd2; bus.md_data = 32'h2;
    #1;
    chk1("rst_ld_ready", bus.ld_ready, 1'b0);
    chk1("rst_md_ready", bus.md_ready, 1'b0);
    chk1("rst_we", bus.write_enable, 1'b0);
    chk5("rst_rd", bus.rd, 5'd0);
    chk32("rst_data", bus.write_data, 32'h0);
    step();
    chk1("rst_we_after_edge", bus.write_enable, 1'b0);
    bus.ld_valid = 1'b0; bus.md_valid = 1'b0;
    rst_n = 1'b1;

    // ALU alone
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    step();
    bus.alu_valid = 1'b0;
    chk1("alu_we", bus.write_enable, 1'b1);
    chk5("alu_rd", bus.rd, 5'd5);
    chk32("alu_data", bus.write_data, 32'h1234);
    step();
    chk1("alu_we_one_cycle", bus.write_enable, 1'b0);

    // Round-robin: ld, md, ld, md
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd10; bus.ld_data = 32'hA0A0_A0A0;
    bus.md_valid = 1'b1; bus.md_rd = 5'd11; bus.md_data = 32'hB0B0_B0B0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1("rr_ld_ready", bus.ld_ready, (k % 2) == 0);
      chk1("rr_md_ready", bus.md_ready, (k % 2) == 1);
      step();
      chk1("rr_we", bus.write_enable, 1'b1);
      chk5("rr_rd", bus.rd, ((k % 2) == 0) ? 5'd10 : 5'd11);
      chk32("rr_data", bus.write_data, ((k % 2) == 0) ? 32'hA0A0_A0A0 : 32'hB0B0_B0B0);
    end
    bus.ld_valid = 1'b0; bus.md_valid = 1'b0;

    // Contention: ALU then ld then md
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h0000_0333;
    bus.ld_valid = 1'b1;  bus.ld_rd = 5'd4;  bus.ld_data = 32'h0000_0444;
    bus.md_valid = 1'b1;  bus.md_rd = 5'd6;  bus.md_data = 32'h0000_0666;
    #1;
    chk1("cont_ld_ready0", bus.ld_ready, 1'b0);
    chk1("cont_md_ready0", bus.md_ready, 1'b0);
    step();
    bus.alu_valid = 1'b0;
    chk1("cont_we1", bus.write_enable, 1'b1);
    chk5("cont_rd1", bus.rd, 5'd3);
    #1;
    chk1("cont_ld_ready1", bus.ld_ready, 1'b1);
    chk1("cont_md_ready1", bus.md_ready, 1'b0);
    step();
    bus.ld_valid = 1'b0;
    chk1("cont_we2", bus.write_enable, 1'b1);
    chk5("cont_rd2", bus.rd, 5'd4);
    chk32("cont_data2", bus.write_data, 32'h0000_0444);
    #1;
    chk1("cont_md_ready2", bus.md_ready, 1'b1);
    step();
    bus.md_valid = 1'b0;
    chk1("cont_we3", bus.write_enable, 1'b1);
    chk5("cont_rd3", bus.rd, 5'd6);
    chk32("cont_data3", bus.write_data, 32'h0000_0666);
    step();
    chk1("cont_idle", bus.write_enable, 1'b0);

    // x0 write is accepted and discarded
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'hFFFF_FFFF;
    #1;
    chk1("x0_ld_ready", bus.ld_ready, 1'b1);
    step();
    bus.ld_valid = 1'b0;
    chk1("x0_we", bus.write_enable, 1'b0);
    bus.rs1 = 5'd0;
    #1;
    chk1("x0_busy", bus.rs1_busy, 1'b0);

    // Scoreboard set / clear / no bypass / same-cycle set wins
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd7; bus.rs2 = 5'd7;
    #1;
    chk1("sb_before_issue", bus.rs1_busy, 1'b0);
    step();
    bus.issue_valid = 1'b0;
    chk1("sb_rs1_set", bus.rs1_busy, 1'b1);
    chk1("sb_rs2_set", bus.rs2_busy, 1'b1);
    step();
    chk1("sb_hold", bus.rs1_busy, 1'b1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
    step();
    bus.alu_valid = 1'b0;
    chk1("sb_wr_we", bus.write_enable, 1'b1);
    chk5("sb_wr_rd", bus.rd, 5'd7);
    chk1("sb_no_bypass", bus.rs1_busy, 1'b1);
    step();
    chk1("sb_cleared", bus.rs1_busy, 1'b0);
    bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    chk1("sb_reissue", bus.rs1_busy, 1'b1);
    bus.alu_valid = 1'b1;
    step();
    bus.alu_valid = 1'b0;
    bus.issue_valid = 1'b1;
    chk1("sb_collide_we", bus.write_enable, 1'b1);
    step();
    bus.issue_valid = 1'b0;
    chk1("sb_set_wins", bus.rs1_busy, 1'b1);
    chk1("sb_collide_we_done", bus.write_enable, 1'b0);

    // Reset mid-flight with md rd=9 offered
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    step();
    bus.issue_valid = 1'b0;
    bus.rs1 = 5'd9;
    #1;
    chk1("mid_pending9", bus.rs1_busy, 1'b1);
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_data = 32'h999;
    #1;
    chk1("mid_md_ready", bus.md_ready, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("mid_md_ready_rst", bus.md_ready, 1'b0);
    chk1("mid_we0", bus.write_enable, 1'b0);
    step();
    bus.md_valid = 1'b0;
    chk1("mid_we1", bus.write_enable, 1'b0);
    step();
    chk1("mid_we2", bus.write_enable, 1'b0);
    for (int i = 1; i < 32; i++) begin
      bus.rs1 = 5'(i);
      #1;
      chk1("mid_pending_clear", bus.rs1_busy, 1'b0);
    end

    // Resume after reset
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd12; bus.ld_data = 32'h0000_0C0C;
    #1;
    chk1("resume_ld_ready", bus.ld_ready, 1'b1);
    step();
    bus.ld_valid = 1'b0;
    chk1("resume_we", bus.write_enable, 1'b1);
    chk5("resume_rd", bus.rd, 5'd12);
    chk32("resume_data", bus.write_data, 32'h0000_0C0C);
    step();
    chk1("resume_we_off", bus.write_enable, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
